// File: rtl/alu_accumulator_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared encodings for the ALU accumulator controller: ALU opcodes,
//   command kinds, FSM states and the settle counter width.
//   Ports: none (package).
package alu_ctrl_pkg;

    // ALU opcodes as {op0,op1,op2}; op0 is bit 2.
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SUM  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_TWOS = 3'b111;

    // Command kinds carried on cmd_kind.
    localparam logic [1:0] K_LOAD_A = 2'b00;
    localparam logic [1:0] K_LOAD_B = 2'b01;
    localparam logic [1:0] K_EXEC   = 2'b10;
    localparam logic [1:0] K_READ   = 2'b11;

    // Settle counter width; covers SETTLE up to 15.
    localparam int SETTLE_CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    // Counter preload for a given settle time: the capture happens on the
    // cycle the counter reads zero, so SETTLE cycles need SETTLE-1.
    function automatic logic [SETTLE_CW-1:0] settle_preload(input int unsigned settle);
        return SETTLE_CW'(settle - 1);
    endfunction

endpackage

// File: rtl/alu_accumulator_ctrl_if.sv
// alu_ctrl_if
//   Command and response valid/ready channels of the accumulator controller.
//   master: command producer / response consumer.
//   slave : the controller itself.
//   Signals: cmd_valid, cmd_ready, cmd_kind[1:0], cmd_op[2:0], cmd_data[WIDTH],
//            rsp_valid, rsp_ready, rsp_data[WIDTH], rsp_carry.
interface alu_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_kind;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;

    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry
    );
endinterface

// File: rtl/alu_accumulator_ctrl_settle_counter.sv
// alu_settle_counter
//   Down-counter timing how long the ALU inputs are held before sampling.
//   clk, reset_n : clock, async active-low reset (count clears to 0)
//   load         : load load_val (has priority over dec)
//   load_val     : preload value
//   dec          : decrement by one; holds at zero
//   zero         : count is zero
module alu_settle_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_accumulator_ctrl.sv
// alu_accumulator_ctrl
//   Sequential front-end for an external 4-bit combinational ALU. Holds two
//   accumulators, drives the ALU from registers, captures out/carry back into
//   AccA after a programmable settle time, and returns results on a
//   valid/ready response channel.
//   clk, reset_n : clock, async active-low reset
//   bus          : command/response channels (alu_ctrl_if.slave)
//   alu_x/alu_y  : AccA / AccB to the ALU (MSB drives x0/y0)
//   alu_op       : registered opcode (bit 2 drives op0)
//   alu_out      : ALU result (MSB is out0)
//   alu_carry    : ALU carry
module alu_accumulator_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_ctrl_if.slave        bus,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry
);

    localparam logic [SETTLE_CW-1:0] CNT_PRELOAD = settle_preload(SETTLE);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] acc_a_d, acc_a_q;
    logic [WIDTH-1:0] acc_b_d, acc_b_q;
    logic [2:0]       op_d, op_q;
    logic             carry_d, carry_q;
    logic             rsp_valid_d, rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_d, rsp_data_q;
    logic             rsp_carry_d, rsp_carry_q;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    // Counter only runs while waiting on the ALU; it sits at zero otherwise.
    assign cnt_dec = (state_q == S_SETTLE);

    alu_settle_counter #(
        .CW(SETTLE_CW)
    ) u_settle (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (CNT_PRELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        cnt_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_kind)
                        K_LOAD_A: acc_a_d = bus.cmd_data;
                        K_LOAD_B: acc_b_d = bus.cmd_data;
                        K_EXEC: begin
                            op_d     = bus.cmd_op;
                            cnt_load = 1'b1;
                            state_d  = S_SETTLE;
                        end
                        default: begin // K_READ
                            rsp_data_d  = acc_a_q;
                            rsp_carry_d = carry_q;
                            rsp_valid_d = 1'b1;
                            state_d     = S_RESP;
                        end
                    endcase
                end
            end
            S_SETTLE: begin
                // ALU inputs have been stable for SETTLE cycles by now.
                if (cnt_zero) begin
                    acc_a_d     = alu_out;
                    carry_d     = alu_carry;
                    rsp_data_d  = alu_out;
                    rsp_carry_d = alu_carry;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            op_q        <= OP_AND;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;

    assign alu_x  = acc_a_q;
    assign alu_y  = acc_b_q;
    assign alu_op = op_q;

endmodule

// File: tb/tb_alu_accumulator_ctrl.sv
// Bench for alu_accumulator_ctrl: a behavioural ALU drives both DUT copies
// (SETTLE=1 and SETTLE=4); a transaction-level model of the SETTLE=1 copy is
// compared every cycle, with literal expectations on top.
module tb_alu_accumulator_ctrl;

    localparam int W = 4;
    localparam int P_SETTLE = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    alu_ctrl_if #(.WIDTH(W)) bus1 ();
    alu_ctrl_if #(.WIDTH(W)) bus4 ();

    logic [W-1:0] x1, y1, o1, x4, y4, o4;
    logic [2:0]   op1, op4;
    logic         c1, c4;

    // Behavioural ALU: {carry, out} for opcode {op0,op1,op2}.
    function automatic logic [W:0] alu_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] op);
        logic [W:0] xe, ye;
        xe = {1'b0, x};
        ye = {1'b0, y};
        case (op)
            3'b000: return {1'b0, x & y};
            3'b001: return {1'b0, ~x};
            3'b010: return {1'b0, x | y};
            3'b011: return {1'b0, x ^ y};
            3'b100: return xe << 1;
            3'b101: return xe + ye;
            3'b110: return xe - ye;
            default: return {1'b0, ~x} + 1'b1;
        endcase
    endfunction

    assign {c1, o1} = alu_ref(x1, y1, op1);
    assign {c4, o4} = alu_ref(x4, y4, op4);

    alu_accumulator_ctrl #(.WIDTH(W), .SETTLE(P_SETTLE)) u_dut (
        .clk(clk), .reset_n(rst_n), .bus(bus1),
        .alu_x(x1), .alu_y(y1), .alu_op(op1), .alu_out(o1), .alu_carry(c1)
    );

    alu_accumulator_ctrl #(.WIDTH(W), .SETTLE(4)) u_dut4 (
        .clk(clk), .reset_n(rst4_n), .bus(bus4),
        .alu_x(x4), .alu_y(y4), .alu_op(op4), .alu_out(o4), .alu_carry(c4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: accumulators, a countdown to the result and a
    // pending-response flag.
    logic [W-1:0] m_a = '0, m_b = '0, m_rd = '0;
    logic [2:0]   m_op = '0;
    logic         m_c = 1'b0, m_rc = 1'b0, m_rv = 1'b0;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0; m_b <= '0; m_op <= '0; m_c <= 1'b0;
            m_rd <= '0; m_rc <= 1'b0; m_rv <= 1'b0; m_left <= 0;
        end else if (m_rv) begin
            if (bus1.rsp_ready) m_rv <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_a  <= W'(alu_ref(m_a, m_b, m_op));
                m_rd <= W'(alu_ref(m_a, m_b, m_op));
                m_c  <= alu_ref(m_a, m_b, m_op) >> W;
                m_rc <= alu_ref(m_a, m_b, m_op) >> W;
                m_rv <= 1'b1;
            end
        end else if (bus1.cmd_valid) begin
            case (bus1.cmd_kind)
                2'b00: m_a <= bus1.cmd_data;
                2'b01: m_b <= bus1.cmd_data;
                2'b10: begin m_op <= bus1.cmd_op; m_left <= P_SETTLE; end
                default: begin m_rd <= m_a; m_rc <= m_c; m_rv <= 1'b1; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmd_ready", bus1.cmd_ready, (m_left == 0) && !m_rv);
            chk("rsp_valid", bus1.rsp_valid, m_rv);
            chk("rsp_data", bus1.rsp_data, m_rd);
            chk("rsp_carry", bus1.rsp_carry, m_rc);
            chk("alu_x", x1, m_a);
            chk("alu_y", y1, m_b);
            chk("alu_op", op1, m_op);
        end
    end

    // Present a command on bus1 and hold it until accepted (called at posedge+2).
    task automatic send(input logic [1:0] kind, input logic [2:0] op, input logic [W-1:0] data);
        logic r;
        logic ok;
        ok = 1'b0;
        bus1.cmd_valid = 1'b1; bus1.cmd_kind = kind; bus1.cmd_op = op; bus1.cmd_data = data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); r = bus1.cmd_ready;
            @(posedge clk); #2;
            if (r) begin ok = 1'b1; break; end
        end
        bus1.cmd_valid = 1'b0;
        chk("cmd_accept", ok, 1'b1);
    endtask

    // Wait for a response on bus1 and check literal value and latency.
    task automatic wait_rsp(input string nm, input logic [W-1:0] d, input logic c, input int lat);
        int n;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus1.rsp_valid) begin n = i; break; end
        end
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_data"}, bus1.rsp_data, d);
        chk({nm, "_carry"}, bus1.rsp_carry, c);
        @(posedge clk); #2;
    endtask

    task automatic exec_lit(input string nm, input logic [2:0] op, input logic [W-1:0] d, input logic c);
        send(2'b10, op, '0);
        wait_rsp(nm, d, c, P_SETTLE + 1);
    endtask

    initial begin
        bus1.cmd_valid = 1'b1; bus1.cmd_kind = 2'b00; bus1.cmd_op = 3'b000; bus1.cmd_data = 4'hF;
        bus1.rsp_ready = 1'b1;
        bus4.cmd_valid = 1'b1; bus4.cmd_kind = 2'b00; bus4.cmd_op = 3'b000; bus4.cmd_data = 4'hF;
        bus4.rsp_ready = 1'b1;

        // Reset held 3 cycles with a command pending.
        repeat (3) @(posedge clk);
        #1 cmp_en = 1'b1;
        #1 bus1.cmd_valid = 1'b0; bus4.cmd_valid = 1'b0;
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
        chk("rst_acc_a", x1, 4'h0);
        chk("rst_acc_b", y1, 4'h0);
        chk("rst_rsp_valid", bus1.rsp_valid, 1'b0);
        chk("rst_cmd_ready", bus1.cmd_ready, 1'b1);
        @(posedge clk); #2;
        send(2'b11, 3'b000, '0);
        wait_rsp("rst_read", 4'b0000, 1'b0, 1);

        // Basic SHL.
        send(2'b00, 3'b000, 4'b0111);
        send(2'b01, 3'b000, 4'b1110);
        exec_lit("shl", 3'b100, 4'b1110, 1'b0);

        // Logic / arithmetic with A reloaded each time.
        send(2'b00, 3'b000, 4'b0111);
        exec_lit("and", 3'b000, 4'b0110, 1'b0);
        send(2'b00, 3'b000, 4'b0111);
        exec_lit("xor", 3'b011, 4'b1001, 1'b0);
        send(2'b00, 3'b000, 4'b0111);
        exec_lit("sum", 3'b101, 4'b0101, 1'b1);

        // Backpressure: OR result held while rsp_ready low; a second EXEC waits.
        send(2'b00, 3'b000, 4'b0111);
        bus1.rsp_ready = 1'b0;
        send(2'b10, 3'b010, '0);
        bus1.cmd_valid = 1'b1; bus1.cmd_kind = 2'b10; bus1.cmd_op = 3'b000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                chk("bp_valid", bus1.rsp_valid, 1'b1);
                chk("bp_data", bus1.rsp_data, 4'b1111);
                chk("bp_ready", bus1.cmd_ready, 1'b0);
            end
        end
        @(posedge clk); #2;
        bus1.cmd_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hold", bus1.rsp_valid, 1'b1);
        @(negedge clk);
        chk("bp_drop", bus1.rsp_valid, 1'b0);
        @(posedge clk); #2;

        // Chaining SUM then READ.
        send(2'b00, 3'b000, 4'b0001);
        send(2'b01, 3'b000, 4'b0001);
        exec_lit("chain1", 3'b101, 4'b0010, 1'b0);
        exec_lit("chain2", 3'b101, 4'b0011, 1'b0);
        exec_lit("chain3", 3'b101, 4'b0100, 1'b0);
        send(2'b11, 3'b000, '0);
        wait_rsp("chain_read", 4'b0100, 1'b0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus1.cmd_valid = 1'($urandom_range(0, 1));
            bus1.cmd_kind  = 2'($urandom_range(0, 3));
            bus1.cmd_op    = 3'($urandom_range(0, 7));
            bus1.cmd_data  = 4'($urandom_range(0, 15));
            bus1.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
        end
        bus1.cmd_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;

        // SETTLE=4 copy: latency of SUM 0101+0011.
        bus4.cmd_valid = 1'b1; bus4.cmd_kind = 2'b00; bus4.cmd_data = 4'b0101;
        @(negedge clk); chk("s4_ready_a", bus4.cmd_ready, 1'b1);
        @(posedge clk); #2;
        bus4.cmd_kind = 2'b01; bus4.cmd_data = 4'b0011;
        @(negedge clk); chk("s4_ready_b", bus4.cmd_ready, 1'b1);
        @(posedge clk); #2;
        bus4.cmd_kind = 2'b10; bus4.cmd_op = 3'b101;
        @(negedge clk); chk("s4_ready_x", bus4.cmd_ready, 1'b1);
        @(posedge clk); #2;
        bus4.cmd_valid = 1'b0;
        begin
            int n;
            n = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (bus4.rsp_valid) begin n = i; break; end
            end
            chk("s4_lat", n, 5);
            chk("s4_data", bus4.rsp_data, 4'b1000);
            chk("s4_carry", bus4.rsp_carry, 1'b0);
        end
        @(posedge clk); #2;

        // Reset in the 2nd SETTLE cycle of a SUB: result must be dropped.
        bus4.cmd_valid = 1'b1; bus4.cmd_kind = 2'b10; bus4.cmd_op = 3'b110;
        @(posedge clk); #2;
        bus4.cmd_valid = 1'b0;
        @(negedge clk); chk("s4_busy", bus4.cmd_ready, 1'b0);
        @(posedge clk); #2;
        rst4_n = 1'b0;
        @(negedge clk);
        chk("s4_rst_x", x4, 4'h0);
        chk("s4_rst_ready", bus4.cmd_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst4_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("s4_no_rsp", bus4.rsp_valid, 1'b0);
            chk("s4_idle", bus4.cmd_ready, 1'b1);
            chk("s4_acc_a", x4, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_accumulator_ctrl.md
Name: alu_accumulator_ctrl

Overview:
- Sequential front-end for the 4-bit combinational ALU (AND/NOT/OR/XOR/SHIFTLEFT/SUM/SUB/TWOSCOMPLEMENT).
- Owns two accumulators (AccA, AccB), drives the ALU operand/opcode inputs and captures ALU out/carry back into AccA.
- Accepts commands over a valid/ready channel and returns results over a second valid/ready channel.
- Replaces hand-driven stimulus with a reusable controller on the ALU's driving side.

Parameters:
- WIDTH, 4, accumulator and ALU operand width.
- SETTLE, 1, clock cycles the ALU inputs are held stable before out/carry are sampled; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_kind  input  2  00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 READ.
- cmd_op  input  3  ALU opcode {op0,op1,op2}; used by EXEC only.
- cmd_data  input  WIDTH  load value; used by LOAD_A/LOAD_B only.
- alu_x  output  WIDTH  AccA to ALU; bit WIDTH-1 drives x0.
- alu_y  output  WIDTH  AccB to ALU; bit WIDTH-1 drives y0.
- alu_op  output  3  opcode to ALU; bit 2 is op0.
- alu_out  input  WIDTH  ALU result; bit WIDTH-1 is out0.
- alu_carry  input  1  ALU carry.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  result value.
- rsp_carry  output  1  carry flag value.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; AccA=0, AccB=0, alu_op=000, carry flag=0, rsp_valid=0, rsp_data=0, rsp_carry=0, settle counter=0.
  - cmd_ready follows state, so it reads 1 out of reset.
  - Commands are ignored while reset_n is low.
- alu_x=AccA, alu_y=AccB and alu_op=op register are always driven from registers (no combinational path from cmd_* to alu_*).
- Opcode encoding {op0,op1,op2}: 000 AND, 001 NOT, 010 OR, 011 XOR, 100 SHL, 101 SUM, 110 SUB, 111 TWOS. The controller passes all 8 codes through unchanged; no illegal codes exist.
- State IDLE (cmd_ready=1). On cmd_valid&cmd_ready:
  - LOAD_A: AccA<=cmd_data next edge; stay IDLE; no response. One command per cycle sustained.
  - LOAD_B: AccB<=cmd_data; stay IDLE; no response.
  - EXEC: op register<=cmd_op; counter<=SETTLE-1; go SETTLE.
  - READ: rsp_data<=AccA, rsp_carry<=carry flag, rsp_valid<=1; go RESP.
- State SETTLE (cmd_ready=0): counter decrements each cycle. On the cycle the counter is 0:
  - AccA<=alu_out, carry flag<=alu_carry, rsp_data<=alu_out, rsp_carry<=alu_carry, rsp_valid<=1; go RESP.
  - AccB and the op register are unchanged.
- State RESP (cmd_ready=0, rsp_valid=1): rsp_data/rsp_carry stay stable until rsp_valid&rsp_ready, then rsp_valid<=0 and state goes IDLE.
  - No bypass: the next command is accepted at the earliest one cycle after the handshake.
- Latency, EXEC accept to rsp_valid: SETTLE+1 cycles. LOAD has 1-cycle effect. READ: rsp_valid high on the cycle after accept.
- Throughput: EXEC occupancy is SETTLE+2 cycles minimum with rsp_ready tied high.
- Chaining: results accumulate in AccA, e.g. EXEC SUM twice computes A+2B mod 2^WIDTH.
- Reset mid-SETTLE or mid-RESP: immediate return to reset values; the in-flight result is discarded, not delivered.
- rsp_ready high while rsp_valid low has no effect. cmd_valid while cmd_ready low has no effect; the command is not latched.

Decomposition:
- Package alu_ctrl_pkg:
  - localparams for the 8 opcodes (OP_AND..OP_TWOS).
  - cmd_kind codes (K_LOAD_A, K_LOAD_B, K_EXEC, K_READ).
  - FSM state encoding (S_IDLE, S_SETTLE, S_RESP).
- Top module: FSM, accumulators, response register.
- One natural sub-module: alu_settle_counter (load value, decrement, zero flag).
- The ALU itself stays external; the bench instantiates the existing ALU with pin order x0..x3, y0..y3, op0..op2, out0..out3, carry.

Test Plan:
- Reset: hold reset_n low 3 cycles with cmd_valid=1 -> after release AccA=AccB=0, rsp_valid=0, cmd_ready=1; READ returns rsp_data=0000, rsp_carry=0.
- Basic EXEC: LOAD_A 0111, LOAD_B 1110, EXEC 100 (SHL), SETTLE=1 -> rsp_valid 2 cycles after accept, rsp_data=1110, rsp_carry=0 (MSB shifted out); alu_op=100 throughout.
- Logic/arith, reloading A=0111 before each: AND -> 0110; XOR -> 1001; SUM -> 0101 with carry=1. Each result is compared against the bench reference model of the ALU.
- Backpressure: EXEC OR with rsp_ready low for 5 cycles -> rsp_valid stays 1, rsp_data stable at 1111, cmd_ready stays 0; a second EXEC presented meanwhile is not accepted; after rsp_ready rises, rsp_valid drops on the next cycle.
- Chaining + READ: A=0001, B=0001, EXEC SUM three times -> responses 0010, 0011, 0100; following READ returns 0100 with carry=0.
- Reset mid-operation: SETTLE=4, EXEC SUB, assert reset_n low in the 2nd SETTLE cycle -> rsp_valid never rises; AccA=0 and state IDLE after release.
